// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multi-digit common-anode seven-segment display: one digit per slot,
// blank gap at the end of each slot, inputs latched once per frame. Optional blink: SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   nums,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     digit_en,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [3:0]            num,
    output logic                  point,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     SHOW_LAST  = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{1'b1}};
    localparam logic [DIGITS-1:0] DIG0       = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   nums_q, nums_d;
    logic [DIGITS-1:0]     points_q, points_d;
    logic [DIGITS-1:0]     den_q, den_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [3:0]            num_q, num_d;
    logic                  point_q, point_d;
    logic                  fd_q, fd_d;
    logic                  latch_s;
    logic                  visible_s;
`ifdef SEG_SCAN_BLINK_EN
    logic [23:0]           blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [DIGITS-1:0]     bmask_q, bmask_d;
`endif

    // Sequencer: slot/blank timing, digit index, frame boundary and latch strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        latch_s = 1'b0;
        fd_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    latch_s = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            fd_d    = 1'b1;
                            latch_s = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame latch: display data only changes at IDLE->SHOW entry and at the frame wrap.
    always_comb begin
        if (latch_s) begin
            nums_d   = nums;
            points_d = points;
            den_d    = digit_en;
        end else begin
            nums_d   = nums_q;
            points_d = points_q;
            den_d    = den_q;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink phase flips each time the free-running counter wraps; mask follows the frame latch.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 24'd1;
        if (blink_cnt_q == 24'hFFFFFF) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end
        if (latch_s) begin
            bmask_d = blink_mask;
        end else begin
            bmask_d = bmask_q;
        end
    end
`endif

    // Output decode from next-state values so the registered outputs line up with the state.
    always_comb begin
        an_d    = AN_OFF;
        num_d   = 4'hF;
        point_d = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        visible_s = den_d[idx_d] & (phase_d | ~bmask_d[idx_d]);
`else
        visible_s = den_d[idx_d];
`endif
        if (state_d == SHOW) begin
            an_d = ~(DIG0 << idx_d);
            if (visible_s) begin
                num_d   = nums_d[{idx_d, 2'b00} +: 4];
                point_d = points_d[idx_d];
            end else begin
                num_d   = 4'hF;
                point_d = 1'b0;
            end
        end else begin
            an_d = AN_OFF;
        end
    end

    // State, latched data and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            nums_q   <= '0;
            points_q <= '0;
            den_q    <= '0;
            an_q     <= AN_OFF;
            num_q    <= 4'hF;
            point_q  <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            nums_q   <= nums_d;
            points_q <= points_d;
            den_q    <= den_d;
            an_q     <= an_d;
            num_q    <= num_d;
            point_q  <= point_d;
            fd_q     <= fd_d;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink counter and phase start in the visible phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= 24'd0;
            phase_q     <= 1'b1;
            bmask_q     <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            bmask_q     <= bmask_d;
        end
    end
`endif

    assign an         = an_q;
    assign num        = num_q;
    assign point      = point_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, CLK_DIV=8, BLANK_CYC=2).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] nums;
    logic [3:0]  points;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        point;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] sb[$];

    localparam logic [9:0] IDLE_O = {4'hF, 4'hF, 1'b0, 1'b0};

    typedef struct {
        logic [15:0] nums;
        logic [3:0]  pts;
        logic [3:0]  en;
        logic [15:0] exp_codes;
        logic [3:0]  exp_pts;
    } vec_t;

    vec_t tbl[4];

    seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .nums       (nums),
        .points     (points),
        .digit_en   (digit_en),
        .an         (an),
        .num        (num),
        .point      (point),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected {an,num,point,frame_done} at cycle p after the scan was started from IDLE.
    function automatic logic [9:0] exp_out(input int p, input logic [15:0] codes, input logic [3:0] pts);
        int slot;
        int ph;
        logic [3:0] a;
        logic [3:0] n;
        logic pt;
        logic fd;
        slot = (p % 32) / 8;
        ph   = p % 8;
        fd   = ((p % 32) == 0) && (p > 0);
        if (ph < 6) begin
            a       = 4'b1111;
            a[slot] = 1'b0;
            n       = codes[slot*4 +: 4];
            pt      = pts[slot];
        end else begin
            a  = 4'hF;
            n  = 4'hF;
            pt = 1'b0;
        end
        return {a, n, pt, fd};
    endfunction

    task automatic check(input logic [9:0] got, input logic [9:0] want, input string nm);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got an=%b num=%h pt=%b fd=%b, expected an=%b num=%h pt=%b fd=%b",
                     nm, got[9:6], got[5:2], got[1], got[0], want[9:6], want[5:2], want[1], want[0]);
        end
    endtask

    task automatic step(input logic [9:0] e, input string nm);
        logic [9:0] want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        check({an, num, point, frame_done}, want, nm);
    endtask

    task automatic start_scan(input logic [15:0] n, input logic [3:0] p, input logic [3:0] e);
        enable = 1'b0;
        step(IDLE_O, "to_idle");
        nums     = n;
        points   = p;
        digit_en = e;
        enable   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{nums: 16'h4321, pts: 4'b0010, en: 4'hF,    exp_codes: 16'h4321, exp_pts: 4'b0010};
        tbl[1] = '{nums: 16'h9876, pts: 4'b1001, en: 4'b1011, exp_codes: 16'h9F76, exp_pts: 4'b1001};
        tbl[2] = '{nums: 16'hFEDC, pts: 4'b1111, en: 4'b0110, exp_codes: 16'hFEDF, exp_pts: 4'b0110};
        tbl[3] = '{nums: 16'h0A5B, pts: 4'b0100, en: 4'hF,    exp_codes: 16'h0A5B, exp_pts: 4'b0100};

        clk = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        nums = 16'h0;
        points = 4'h0;
        digit_en = 4'h0;
        #12;
        check({an, num, point, frame_done}, IDLE_O, "reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step(IDLE_O, "idle_disabled");

        // Table-driven vectors: two full frames plus the next frame boundary.
        for (int i = 0; i < 4; i++) begin
            start_scan(tbl[i].nums, tbl[i].pts, tbl[i].en);
            for (int p = 0; p <= 64; p++)
                step(exp_out(p, tbl[i].exp_codes, tbl[i].exp_pts), $sformatf("vec%0d_p%0d", i, p));
        end

        // Mid-frame data change during digit 1 only takes effect next frame.
        start_scan(16'h4321, 4'b0010, 4'hF);
        for (int p = 0; p <= 64; p++) begin
            step(exp_out(p, (p < 32) ? 16'h4321 : 16'h9876, 4'b0010), $sformatf("midchg_p%0d", p));
            if (p == 10) nums = 16'h9876;
        end

        // Enable dropped during digit 2 SHOW: blank at once, no frame_done, restart at digit 0.
        start_scan(16'hABCD, 4'b0001, 4'hF);
        for (int p = 0; p <= 18; p++)
            step(exp_out(p, 16'hABCD, 4'b0001), $sformatf("drop_p%0d", p));
        enable = 1'b0;
        for (int k = 0; k < 40; k++) step(IDLE_O, "dropped_idle");
        nums   = 16'h5678;
        points = 4'b0000;
        enable = 1'b1;
        for (int p = 0; p <= 9; p++)
            step(exp_out(p, 16'h5678, 4'b0000), $sformatf("reen_p%0d", p));

        // Asynchronous reset in the middle of digit 1's slot.
        #2;
        rst = 1'b1;
        #1;
        check({an, num, point, frame_done}, IDLE_O, "async_reset");
        #2;
        rst = 1'b0;
        for (int p = 0; p <= 8; p++)
            step(exp_out(p, 16'h5678, 4'b0000), $sformatf("post_rst_p%0d", p));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
